// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings and constants.
package ifu_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } ifu_state_t;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register: reset load, aligned redirect load, sequential +4 advance.
module ifu_pc_reg
    import ifu_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            advance,
    input  logic [XLEN-1:0] base,
    output logic [XLEN-1:0] pc
);

    // Redirect outranks the sequential advance; the add wraps naturally at 2^XLEN.
    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (redirect_valid)
            pc <= {redirect_target[XLEN-1:2], 2'b00};
        else if (advance)
            pc <= base + XLEN'(4);
    end

endmodule

// File: rtl/ifu_fetch.sv
// RV32I fetch stage: one outstanding word fetch, output register toward decode, redirect with stale drop.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            ins_valid,
    input  logic            ins_ready,
    output logic [XLEN-1:0] ins_data,
    output logic [XLEN-1:0] ins_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target
);

    ifu_state_t      state;
    logic            drop;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            advance;

    assign imem_req_valid = (state == S_REQ) && !rst;
    assign imem_req_addr  = pc;
    assign advance        = (state == S_OUT) && ins_ready;

    ifu_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .advance         (advance),
        .base            (ins_pc),
        .pc              (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            drop      <= 1'b0;
            req_pc    <= RESET_PC;
            ins_valid <= 1'b0;
            ins_data  <= XLEN'(NOP_INSN);
            ins_pc    <= RESET_PC;
        end else begin
            unique case (state)
                S_REQ: begin
                    // A redirect coinciding with acceptance makes this fetch stale.
                    if (imem_req_ready) begin
                        state  <= S_WAIT;
                        req_pc <= pc;
                        drop   <= redirect_valid;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop || redirect_valid) begin
                            state <= S_REQ;
                            drop  <= 1'b0;
                        end else begin
                            ins_data  <= imem_rsp_data;
                            ins_pc    <= req_pc;
                            ins_valid <= 1'b1;
                            state     <= S_OUT;
                        end
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (redirect_valid || ins_ready) begin
                        ins_valid <= 1'b0;
                        state     <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed vector table, corner-case sequences, random traffic vs. a stream model.
module tb_ifu_fetch;
    import ifu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_ready, imem_rsp_valid, ins_ready, redirect_valid;
    logic [31:0] imem_rsp_data, redirect_target;
    logic        imem_req_valid, ins_valid;
    logic [31:0] imem_req_addr, ins_data, ins_pc;
    logic        w_req_valid, w_ins_valid;
    logic [31:0] w_req_addr, w_ins_data, w_ins_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk (clk), .rst (rst),
        .imem_req_valid (imem_req_valid), .imem_req_ready (imem_req_ready),
        .imem_req_addr (imem_req_addr), .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data), .ins_valid (ins_valid),
        .ins_ready (ins_ready), .ins_data (ins_data), .ins_pc (ins_pc),
        .redirect_valid (redirect_valid), .redirect_target (redirect_target)
    );

    ifu_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk (clk), .rst (rst),
        .imem_req_valid (w_req_valid), .imem_req_ready (imem_req_ready),
        .imem_req_addr (w_req_addr), .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data), .ins_valid (w_ins_valid),
        .ins_ready (ins_ready), .ins_data (w_ins_data), .ins_pc (w_ins_pc),
        .redirect_valid (redirect_valid), .redirect_target (redirect_target)
    );

    typedef struct {
        logic        req_ready, rsp_valid;
        logic [31:0] rsp_data;
        logic        ins_ready, rd_valid;
        logic [31:0] rd_target;
        logic        e_req_valid;
        logic [31:0] e_req_addr;
        logic        e_ins_valid;
        logic [31:0] e_ins_data, e_ins_pc;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        ins_ready = 0; redirect_valid = 0; redirect_target = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        #1;
        chk("rst_req_valid_gated", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_ins_valid", {31'd0, ins_valid}, 32'd0);
        chk("rst_ins_data", ins_data, NOP_INSN);
        chk("rst_ins_pc", ins_pc, 32'h0);
        chk("rst_w_ins_pc", w_ins_pc, 32'hFFFF_FFFC);
        rst = 1'b0;
        #1;
        chk("rst_first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("rst_first_req_addr", imem_req_addr, 32'h0);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0013;
    endfunction

    initial begin
        // inputs: rr rv data ir rd target | expected: req_valid addr ins_valid data pc
        tv[0]  = '{1, 0, 32'h0,        0, 0, 32'h0,   1, 32'h0,   0, NOP_INSN,     32'h0};
        tv[1]  = '{0, 1, 32'h00500093, 0, 0, 32'h0,   0, 32'h0,   0, NOP_INSN,     32'h0};
        tv[2]  = '{0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   1, 32'h00500093, 32'h0};
        tv[3]  = '{0, 0, 32'h0,        1, 0, 32'h0,   0, 32'h0,   1, 32'h00500093, 32'h0};
        tv[4]  = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h4,   0, 32'h00500093, 32'h0};
        tv[5]  = '{0, 0, 32'h0,        0, 1, 32'h103, 1, 32'h4,   0, 32'h00500093, 32'h0};
        tv[6]  = '{1, 0, 32'h0,        0, 0, 32'h0,   1, 32'h100, 0, 32'h00500093, 32'h0};
        tv[7]  = '{0, 1, 32'h11111111, 0, 1, 32'h200, 0, 32'h0,   0, 32'h00500093, 32'h0};
        tv[8]  = '{1, 0, 32'h0,        0, 0, 32'h0,   1, 32'h200, 0, 32'h00500093, 32'h0};
        tv[9]  = '{0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h00500093, 32'h0};
        tv[10] = '{0, 1, 32'h22222222, 0, 0, 32'h0,   0, 32'h0,   0, 32'h00500093, 32'h0};
        tv[11] = '{0, 0, 32'h0,        1, 1, 32'h40,  0, 32'h0,   1, 32'h22222222, 32'h200};
        tv[12] = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h40,  0, 32'h22222222, 32'h200};

        rst = 1'b1;
        idle_inputs();
        @(negedge clk);

        // Directed vector table
        do_reset();
        for (int i = 0; i < 13; i++) begin
            imem_req_ready  = tv[i].req_ready;
            imem_rsp_valid  = tv[i].rsp_valid;
            imem_rsp_data   = tv[i].rsp_data;
            ins_ready       = tv[i].ins_ready;
            redirect_valid  = tv[i].rd_valid;
            redirect_target = tv[i].rd_target;
            #1;
            chk($sformatf("tv%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, tv[i].e_req_valid});
            if (tv[i].e_req_valid)
                chk($sformatf("tv%0d_req_addr", i), imem_req_addr, tv[i].e_req_addr);
            chk($sformatf("tv%0d_ins_valid", i), {31'd0, ins_valid}, {31'd0, tv[i].e_ins_valid});
            chk($sformatf("tv%0d_ins_data", i), ins_data, tv[i].e_ins_data);
            chk($sformatf("tv%0d_ins_pc", i), ins_pc, tv[i].e_ins_pc);
            step();
        end
        idle_inputs();

        // Decode backpressure for 5 cycles
        do_reset();
        imem_req_ready = 1; step();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h00A00113; step();
        imem_rsp_valid = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ins_valid", {31'd0, ins_valid}, 32'd1);
            chk("bp_ins_data", ins_data, 32'h00A00113);
            chk("bp_ins_pc", ins_pc, 32'h0);
            chk("bp_no_req", {31'd0, imem_req_valid}, 32'd0);
            step();
        end
        ins_ready = 1; step();
        ins_ready = 0; #1;
        chk("bp_next_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("bp_next_req_addr", imem_req_addr, 32'h4);

        // Redirect during S_WAIT, memory latency 4
        do_reset();
        imem_req_ready = 1; step();
        imem_req_ready = 0; redirect_valid = 1; redirect_target = 32'h0000_0103; step();
        redirect_valid = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rw_wait_no_req", {31'd0, imem_req_valid}, 32'd0);
            step();
        end
        imem_rsp_valid = 1; imem_rsp_data = 32'hBAD0_0093; step();
        imem_rsp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rw_stale_ins_valid", {31'd0, ins_valid}, 32'd0);
            chk("rw_req_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("rw_req_addr", imem_req_addr, 32'h100);
            step();
        end

        // Reset during S_WAIT, late response
        do_reset();
        imem_req_ready = 1; step();
        imem_req_ready = 0; rst = 1; #1;
        chk("rm_req_gated", {31'd0, imem_req_valid}, 32'd0);
        step();
        rst = 0; imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF; #1;
        chk("rm_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("rm_ins_valid0", {31'd0, ins_valid}, 32'd0);
        step();
        imem_rsp_valid = 0; #1;
        chk("rm_ins_valid1", {31'd0, ins_valid}, 32'd0);
        chk("rm_req_addr", imem_req_addr, 32'h0);
        chk("rm_ins_data", ins_data, NOP_INSN);

        // PC wrap on the second instance
        do_reset();
        chk("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1; step();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h00000013; step();
        imem_rsp_valid = 0; #1;
        chk("wrap_ins_valid", {31'd0, w_ins_valid}, 32'd1);
        chk("wrap_ins_pc", w_ins_pc, 32'hFFFF_FFFC);
        ins_ready = 1; step();
        ins_ready = 0; #1;
        chk("wrap_req_valid", {31'd0, w_req_valid}, 32'd1);
        chk("wrap_req_addr", w_req_addr, 32'h0);

        // Random traffic against an instruction-stream model
        begin
            logic        outst, hold;
            int          cnt, idle, delivered;
            logic [31:0] pend, exp_pc, hold_data, hold_pc;
            outst = 0; hold = 0; cnt = 0; idle = 0; delivered = 0;
            pend = 0; exp_pc = 0; hold_data = 0; hold_pc = 0;
            do_reset();
            for (int cyc = 0; cyc < 3000; cyc++) begin
                if (hold) begin
                    chk("rnd_hold_valid", {31'd0, ins_valid}, 32'd1);
                    chk("rnd_hold_data", ins_data, hold_data);
                    chk("rnd_hold_pc", ins_pc, hold_pc);
                end
                imem_req_ready  = ($urandom_range(0, 2) != 0);
                imem_rsp_valid  = outst && (cnt == 0);
                imem_rsp_data   = mem_word(pend);
                ins_ready       = ($urandom_range(0, 2) != 0);
                redirect_valid  = ($urandom_range(0, 15) == 0);
                redirect_target = $urandom;
                #1;
                if (imem_rsp_valid) outst = 0;
                else if (outst) cnt--;
                if (imem_req_valid && imem_req_ready) begin
                    chk("rnd_single_outstanding", {31'd0, outst}, 32'd0);
                    chk("rnd_addr_aligned", {30'd0, imem_req_addr[1:0]}, 32'd0);
                    outst = 1;
                    cnt   = $urandom_range(0, 3);
                    pend  = imem_req_addr;
                end
                if (ins_valid && ins_ready) begin
                    chk("rnd_ins_pc", ins_pc, exp_pc);
                    chk("rnd_ins_data", ins_data, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    delivered++;
                    idle = 0;
                end else begin
                    idle++;
                end
                if (redirect_valid) exp_pc = {redirect_target[31:2], 2'b00};
                hold      = ins_valid && !ins_ready && !redirect_valid;
                hold_data = ins_data;
                hold_pc   = ins_pc;
                if (idle > 80) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_progress got %0d idle cycles limit 80", idle);
                    break;
                end
                step();
            end
            chk("rnd_delivered_some", {31'd0, delivered > 100}, 32'd1);
        end

        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
